block_manager: RTL



---
 rtl/block_manager.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/block_manager.sv
// block_manager: level-flow sequencer and block layout / retire logic feeding color_mapper.
// Tracks the game state, loads each level's fixed block layout, and once per video
// frame scans the ten blocks against both balls, retiring any block a ball touches.
// Optional feature: define BLOCK_SCORE_EN to add an 8-bit saturating retired-block score.
module block_manager #(
    parameter int TITLE_FRAMES = 120,
    parameter int NUM_BLOCKS   = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic [9:0] BallX       [0:1],
    input  logic [9:0] BallY       [0:1],
    input  logic [9:0] Ball_size   [0:1],
    output logic [9:0] BlockX      [0:NUM_BLOCKS-1],
    output logic [9:0] BlockY      [0:NUM_BLOCKS-1],
    output logic [9:0] Block_size  [0:NUM_BLOCKS-1],
    output logic       block_ready [0:NUM_BLOCKS-1],
    output logic       level_one,
    output logic       level_two,
`ifdef BLOCK_SCORE_EN
    output logic [7:0] score,
`endif
    output logic       game_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_TITLE,
        ST_L1_PLAY,
        ST_L2_TITLE,
        ST_L2_PLAY,
        ST_DONE
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [2:0]             sync_reg;
    logic                   frame_tick_reg;
    logic [15:0]            title_cnt_reg;
    logic                   scan_active_reg;
    logic [3:0]             scan_idx_reg;
    logic                   level_check_reg;
    logic                   play_entry_reg;
    logic [NUM_BLOCKS-1:0]  ready_reg;
    logic [9:0]             block_x_reg [0:NUM_BLOCKS-1];
    logic [9:0]             block_y_reg [0:NUM_BLOCKS-1];
    logic [9:0]             block_s_reg [0:NUM_BLOCKS-1];

    logic                   in_title;
    logic                   in_play;
    logic                   enter_l1;
    logic                   enter_l2;
    logic                   enter_play;
    logic                   retire;
    logic [1:0]             ball_hit;
    logic [10:0]            blk_x;
    logic [10:0]            blk_y;
    logic [10:0]            blk_s;

    genvar gi;

    assign in_title   = (state_reg == ST_L1_TITLE) || (state_reg == ST_L2_TITLE);
    assign in_play    = (state_reg == ST_L1_PLAY)  || (state_reg == ST_L2_PLAY);
    assign enter_l1   = (state_next == ST_L1_TITLE) && (state_reg != ST_L1_TITLE);
    assign enter_l2   = (state_next == ST_L2_TITLE) && (state_reg != ST_L2_TITLE);
    assign enter_play = ((state_next == ST_L1_PLAY) && (state_reg == ST_L1_TITLE)) ||
                        ((state_next == ST_L2_PLAY) && (state_reg == ST_L2_TITLE));

    // Bring vsync into the Clk domain and register a single-cycle rising-edge tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_reg       <= 3'b000;
            frame_tick_reg <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[1:0], frame_clk};
            frame_tick_reg <= sync_reg[1] & ~sync_reg[2];
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: titles run for TITLE_FRAMES ticks, plays end after a scan leaves no live block.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = ST_L1_TITLE;
            end
            ST_L1_TITLE: begin
                if (frame_tick_reg && (title_cnt_reg == 16'(TITLE_FRAMES - 1))) state_next = ST_L1_PLAY;
            end
            ST_L1_PLAY: begin
                if (level_check_reg && (ready_reg == '0)) state_next = ST_L2_TITLE;
            end
            ST_L2_TITLE: begin
                if (frame_tick_reg && (title_cnt_reg == 16'(TITLE_FRAMES - 1))) state_next = ST_L2_PLAY;
            end
            ST_L2_PLAY: begin
                if (level_check_reg && (ready_reg == '0)) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Flag outputs decoded straight from the state.
    always_comb begin
        level_one = 1'b0;
        level_two = 1'b0;
        game_done = 1'b0;
        case (state_reg)
            ST_L1_TITLE: level_one = 1'b1;
            ST_L2_TITLE: level_two = 1'b1;
            ST_DONE:     game_done = 1'b1;
            default: ;
        endcase
    end

    // Title frame counter, restarted on entry to either title state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            title_cnt_reg <= '0;
        end else if (enter_l1 || enter_l2) begin
            title_cnt_reg <= '0;
        end else if (in_title && frame_tick_reg) begin
            title_cnt_reg <= title_cnt_reg + 16'd1;
        end
    end

    // Scan sequencer: a tick in PLAY walks blocks 0..9, then flags the level-clear check.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            scan_active_reg <= 1'b0;
            scan_idx_reg    <= '0;
            level_check_reg <= 1'b0;
            play_entry_reg  <= 1'b0;
        end else begin
            level_check_reg <= 1'b0;
            play_entry_reg  <= enter_play;
            if (!in_play) begin
                scan_active_reg <= 1'b0;
                scan_idx_reg    <= '0;
            end else if (scan_active_reg) begin
                if (scan_idx_reg == 4'(NUM_BLOCKS - 1)) begin
                    scan_active_reg <= 1'b0;
                    scan_idx_reg    <= '0;
                    level_check_reg <= 1'b1;
                end else begin
                    scan_idx_reg <= scan_idx_reg + 4'd1;
                end
            end else if (frame_tick_reg) begin
                scan_active_reg <= 1'b1;
                scan_idx_reg    <= '0;
            end
        end
    end

    assign blk_x = {1'b0, block_x_reg[scan_idx_reg]};
    assign blk_y = {1'b0, block_y_reg[scan_idx_reg]};
    assign blk_s = {1'b0, block_s_reg[scan_idx_reg]};

    // Overlap test of the block under scan against each ball, widened to avoid any subtraction.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ball
            logic [10:0] bx;
            logic [10:0] by;
            logic [10:0] br;
            assign bx = {1'b0, BallX[gi]};
            assign by = {1'b0, BallY[gi]};
            assign br = {1'b0, Ball_size[gi]};
            assign ball_hit[gi] = (bx + br >= blk_x) && (bx <= blk_x + blk_s + br) &&
                                  (by + br >= blk_y) && (by <= blk_y + blk_s + br);
        end
    endgenerate

    assign retire = in_play && scan_active_reg && ready_reg[scan_idx_reg] && (|ball_hit);

    // Layout load on title entry, all blocks live one cycle into PLAY, retire hit blocks during scan.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ready_reg <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                block_x_reg[i] <= '0;
                block_y_reg[i] <= '0;
                block_s_reg[i] <= '0;
            end
        end else if (enter_l1) begin
            ready_reg <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                block_x_reg[i] <= 10'(40 + 60 * i);
                block_y_reg[i] <= 10'd200;
                block_s_reg[i] <= 10'd16;
            end
        end else if (enter_l2) begin
            ready_reg <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                block_x_reg[i] <= (i < 5) ? 10'(80 + 100 * i) : 10'(80 + 100 * (i - 5));
                block_y_reg[i] <= (i < 5) ? 10'd150 : 10'd300;
                block_s_reg[i] <= 10'd12;
            end
        end else if (play_entry_reg) begin
            ready_reg <= '1;
        end else if (retire) begin
            ready_reg[scan_idx_reg] <= 1'b0;
        end
    end

    generate
        for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_out
            assign BlockX[gi]      = block_x_reg[gi];
            assign BlockY[gi]      = block_y_reg[gi];
            assign Block_size[gi]  = block_s_reg[gi];
            assign block_ready[gi] = ready_reg[gi];
        end
    endgenerate

`ifdef BLOCK_SCORE_EN
    logic [7:0] score_reg;

    // Retired-block score: cleared on a new game, saturating at 255, kept across levels.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            score_reg <= '0;
        end else if (enter_l1) begin
            score_reg <= '0;
        end else if (retire && (score_reg != 8'hFF)) begin
            score_reg <= score_reg + 8'd1;
        end
    end

    assign score = score_reg;
`endif

endmodule
